// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU among NUM_REQUESTERS execution slots.
// A grant latches operands, pulses alu_enable for one cycle, and returns the result via valid/ready.
module alu_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int PC_WIDTH       = 8,
  parameter int INSTR_WIDTH    = 5,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQUESTERS-1:0]             req_valid,
  output logic [NUM_REQUESTERS-1:0]             req_ready,
  input  logic [NUM_REQUESTERS*PC_WIDTH-1:0]    req_pc,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]  req_imm,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]  req_rs1,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]  req_rs2,
  input  logic [NUM_REQUESTERS*INSTR_WIDTH-1:0] req_instruction,
  output logic [NUM_REQUESTERS-1:0]             resp_valid,
  input  logic [NUM_REQUESTERS-1:0]             resp_ready,
  output logic [DATA_WIDTH-1:0]                 resp_data,
  output logic                                  alu_enable,
  output logic [PC_WIDTH-1:0]                   alu_pc,
  output logic [DATA_WIDTH-1:0]                 alu_imm,
  output logic [DATA_WIDTH-1:0]                 alu_rs1,
  output logic [DATA_WIDTH-1:0]                 alu_rs2,
  output logic [INSTR_WIDTH-1:0]                alu_instruction,
  input  logic [DATA_WIDTH-1:0]                 alu_out,
  output logic                                  busy,
  output logic [ID_WIDTH-1:0]                   grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ID_WIDTH-1:0] last;
  logic [ID_WIDTH-1:0] pick;
  logic [ID_WIDTH-1:0] cand;
  logic                pick_found;
  logic                grant_fire;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      cand = ID_WIDTH'((int'(last) + k) % NUM_REQUESTERS);
      if (!pick_found && req_valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  assign grant_fire = (state == ST_IDLE) && pick_found;

  // Reset gating keeps the grant quiet while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (reset && grant_fire) begin
      req_ready[pick] = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (grant_fire) state_next = ST_ISSUE;
      ST_ISSUE:   state_next = ST_WAIT;
      ST_WAIT:    state_next = ST_RESPOND;
      ST_RESPOND: if (resp_ready[grant_id]) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state <= state_next;
    end
  end

  // Operand capture, ALU sequencing and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_enable      <= 1'b0;
      alu_pc          <= '0;
      alu_imm         <= '0;
      alu_rs1         <= '0;
      alu_rs2         <= '0;
      alu_instruction <= '0;
      resp_valid      <= '0;
      resp_data       <= '0;
      grant_id        <= '0;
      last            <= ID_WIDTH'(NUM_REQUESTERS - 1);
      busy            <= 1'b0;
    end else begin
      alu_enable <= 1'b0;
      busy       <= (state_next != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            alu_pc          <= req_pc[int'(pick)*PC_WIDTH +: PC_WIDTH];
            alu_imm         <= req_imm[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
            alu_rs1         <= req_rs1[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
            alu_rs2         <= req_rs2[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
            alu_instruction <= req_instruction[int'(pick)*INSTR_WIDTH +: INSTR_WIDTH];
            grant_id        <= pick;
            last            <= pick;
            alu_enable      <= 1'b1;
          end
        end
        ST_WAIT: begin
          // The ALU registered its result on the edge that ended ISSUE.
          resp_data  <= alu_out;
          resp_valid <= NUM_REQUESTERS'(1) << grant_id;
        end
        ST_RESPOND: begin
          if (resp_ready[grant_id]) begin
            resp_valid <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic,
// with a scoreboard fed at grant time and a monitor comparing every cycle.
module tb_alu_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int PW  = 8;
  localparam int IW  = 5;
  localparam int IDW = 2;
  localparam logic [N-1:0] ONE = 1;

  localparam logic [IW-1:0] OP_ADD   = 5'd0;
  localparam logic [IW-1:0] OP_SUB   = 5'd1;
  localparam logic [IW-1:0] OP_ADDI  = 5'd2;
  localparam logic [IW-1:0] OP_AND   = 5'd3;
  localparam logic [IW-1:0] OP_OR    = 5'd4;
  localparam logic [IW-1:0] OP_XOR   = 5'd5;
  localparam logic [IW-1:0] OP_PCREL = 5'd6;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*PW-1:0] req_pc;
  logic [N*DW-1:0] req_imm;
  logic [N*DW-1:0] req_rs1;
  logic [N*DW-1:0] req_rs2;
  logic [N*IW-1:0] req_instruction;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [DW-1:0]   resp_data;
  logic            alu_enable;
  logic [PW-1:0]   alu_pc;
  logic [DW-1:0]   alu_imm;
  logic [DW-1:0]   alu_rs1;
  logic [DW-1:0]   alu_rs2;
  logic [IW-1:0]   alu_instruction;
  logic [DW-1:0]   alu_out;
  logic            busy;
  logic [IDW-1:0]  grant_id;

  always #5 clk = ~clk;

  alu_arbiter #(
    .NUM_REQUESTERS(N), .DATA_WIDTH(DW), .PC_WIDTH(PW), .INSTR_WIDTH(IW), .ID_WIDTH(IDW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_instruction(req_instruction),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .alu_enable(alu_enable), .alu_pc(alu_pc), .alu_imm(alu_imm), .alu_rs1(alu_rs1),
    .alu_rs2(alu_rs2), .alu_instruction(alu_instruction), .alu_out(alu_out),
    .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [DW-1:0] alu_fn(input logic [IW-1:0] op, input logic [PW-1:0] pc,
                                           input logic [DW-1:0] imm, input logic [DW-1:0] rs1,
                                           input logic [DW-1:0] rs2);
    case (op)
      OP_ADD:   return rs1 + rs2;
      OP_SUB:   return rs1 - rs2;
      OP_ADDI:  return rs1 + imm;
      OP_AND:   return rs1 & rs2;
      OP_OR:    return rs1 | rs2;
      OP_XOR:   return rs1 ^ rs2;
      OP_PCREL: return {{(DW-PW){1'b0}}, pc} + imm;
      default:  return rs1 ^ rs2 ^ imm;
    endcase
  endfunction

  // Shared registered ALU: result appears the cycle after alu_enable.
  always @(posedge clk or negedge reset) begin
    if (!reset) alu_out <= '0;
    else if (alu_enable) alu_out <= alu_fn(alu_instruction, alu_pc, alu_imm, alu_rs1, alu_rs2);
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_at(input logic [N-1:0] v, input int j);
    return |((v >> j) & ONE);
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (bit_at(v, i)) return i;
    return -1;
  endfunction

  typedef struct { int id; logic [DW-1:0] data; } resp_t;
  typedef struct { int id; int cyc; } grant_t;

  resp_t         sb[$];
  grant_t        glog[$];
  logic [DW-1:0] rlog[$];

  // Reference model: one operation in flight, phase counts cycles since grant.
  bit           m_free  = 1'b1;
  int           m_last  = N - 1;
  int           m_gid   = 0;
  int           m_phase = 0;
  logic [N-1:0] last_hs = '0;
  resp_t        cur;

  always @(negedge clk) begin : monitor
    logic [N-1:0] exp_ready;
    int           g;
    int           j;
    resp_t        r;
    grant_t       gt;
    if (!reset) begin
      m_free  = 1'b1;
      m_last  = N - 1;
      m_phase = 0;
      last_hs = '0;
      sb.delete();
    end else begin
      exp_ready = '0;
      g = -1;
      if (m_free) begin
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (g < 0 && bit_at(req_valid, j)) g = j;
        end
      end
      if (g >= 0) exp_ready = ONE << g;
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, !m_free);
      check("alu_enable", alu_enable, m_phase == 1);
      if (!m_free) check("grant_id", grant_id, m_gid);
      if (m_phase >= 3) begin
        if (m_phase == 3) begin
          check("sb_depth", sb.size(), 1);
          if (sb.size() > 0) cur = sb.pop_front();
          rlog.push_back(resp_data);
        end
        check("resp_valid", resp_valid, ONE << cur.id);
        check("resp_data", resp_data, cur.data);
      end else begin
        check("resp_valid_idle", resp_valid, '0);
      end
      last_hs = req_valid & req_ready;
      if (last_hs != 0) begin
        gt.id  = onehot_idx(last_hs);
        gt.cyc = cyc;
        glog.push_back(gt);
      end
      if (m_free) begin
        if (g >= 0) begin
          r.id   = g;
          r.data = alu_fn(req_instruction[g*IW +: IW], req_pc[g*PW +: PW], req_imm[g*DW +: DW],
                          req_rs1[g*DW +: DW], req_rs2[g*DW +: DW]);
          sb.push_back(r);
          m_free  = 1'b0;
          m_phase = 1;
          m_gid   = g;
          m_last  = g;
        end
      end else if (m_phase >= 3 && bit_at(resp_ready, m_gid)) begin
        m_free  = 1'b1;
        m_phase = 0;
      end else if (m_phase < 4) begin
        m_phase++;
      end
    end
  end

  // Stimulus side: requesters re-arm or drop after each handshake.
  int           rem[N];
  bit           rand_mode = 1'b0;
  logic [N-1:0] hs_seen = '0;

  task automatic rand_ops(input int i);
    req_instruction[i*IW +: IW] = IW'($urandom_range(0, 7));
    req_pc[i*PW +: PW]          = PW'($urandom);
    req_imm[i*DW +: DW]         = $urandom;
    req_rs1[i*DW +: DW]         = $urandom;
    req_rs2[i*DW +: DW]         = $urandom;
  endtask

  task automatic arm(input int i, input int n);
    rand_ops(i);
    req_valid = req_valid | (ONE << i);
    rem[i] = n;
  endtask

  task automatic set_req(input int i, input logic [IW-1:0] op, input logic [DW-1:0] rs1,
                         input logic [DW-1:0] rs2, input logic [DW-1:0] imm, input int n);
    arm(i, n);
    req_instruction[i*IW +: IW] = op;
    req_rs1[i*DW +: DW] = rs1;
    req_rs2[i*DW +: DW] = rs2;
    req_imm[i*DW +: DW] = imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    hs_seen = last_hs;
    for (int i = 0; i < N; i++) begin
      if (bit_at(hs_seen, i)) begin
        if (rem[i] > 0) rem[i]--;
        if (rem[i] == 0) req_valid = req_valid & ~(ONE << i);
        else rand_ops(i);
      end
    end
    if (rand_mode) begin
      resp_ready = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!bit_at(req_valid, i) && $urandom_range(0, 3) == 0) arm(i, $urandom_range(1, 2));
        else if (bit_at(req_valid, i) && $urandom_range(0, 15) == 0) begin
          req_valid = req_valid & ~(ONE << i);
          rem[i] = 0;
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((req_valid != 0 || busy) && n < 300) begin
      step();
      n++;
    end
    check("drain_bound", n < 300, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic wait_grant(input int i);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bit_at(hs_seen, i) && n < 20);
    check("grant_bound", bit_at(hs_seen, i), 1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int n;
    logic [N-1:0]  snap_rv;
    logic [DW-1:0] snap_rd;
    req_valid = '0; req_pc = '0; req_imm = '0; req_rs1 = '0; req_rs2 = '0;
    req_instruction = '0; resp_ready = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, '0);
    check("rst_resp_valid", resp_valid, '0);
    check("rst_alu_enable", alu_enable, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant_id", grant_id, '0);
    check("rst_resp_data", resp_data, '0);
    check("rst_alu_rs1", alu_rs1, '0);
    reset = 1'b1;
    step();

    // Single operation on requester 1.
    resp_ready = 4'b0010;
    set_req(1, OP_ADD, 32'd5, 32'd7, 32'd0, 1);
    #1 check("single_req_ready", req_ready, 4'b0010);
    step();
    check("single_alu_enable", alu_enable, 1'b1);
    n = 1;
    while (resp_valid == 0 && n < 20) begin
      step();
      n++;
    end
    check("single_latency", n, 3);
    check("single_resp_valid", resp_valid, 4'b0010);
    check("single_resp_data", resp_data, 32'd12);
    step();
    check("single_busy_drop", busy, 1'b0);

    // Two simultaneous requests straight from reset.
    do_reset();
    glog.delete(); rlog.delete();
    resp_ready = '1;
    set_req(0, OP_ADDI, 32'd1, 32'd0, 32'd2, 1);
    set_req(2, OP_SUB, 32'd9, 32'd4, 32'd0, 1);
    drain();
    check("simul_grants", glog.size(), 2);
    check("simul_results", rlog.size(), 2);
    if (glog.size() == 2 && rlog.size() == 2) begin
      check("simul_first_id", glog[0].id, 0);
      check("simul_second_id", glog[1].id, 2);
      check("simul_spacing", glog[1].cyc - glog[0].cyc, 4);
      check("simul_first_data", rlog[0], 32'd3);
      check("simul_second_data", rlog[1], 32'd5);
    end

    // Fairness: all four valid for two grants each.
    do_reset();
    glog.delete();
    for (int i = 0; i < N; i++) arm(i, 2);
    drain();
    check("fair_count", glog.size(), 8);
    if (glog.size() == 8) begin
      for (int i = 0; i < 8; i++) check("fair_order", glog[i].id, i % N);
    end

    // Backpressure in RESPOND with other requests pending.
    resp_ready = '0;
    arm(3, 1); arm(0, 1); arm(1, 1);
    n = 0;
    while (resp_valid == 0 && n < 20) begin
      step();
      n++;
    end
    check("bp_resp_seen", resp_valid != 0, 1'b1);
    snap_rv = resp_valid;
    snap_rd = resp_data;
    repeat (5) begin
      step();
      check("bp_resp_valid", resp_valid, snap_rv);
      check("bp_resp_data", resp_data, snap_rd);
      check("bp_req_ready", req_ready, '0);
      check("bp_alu_enable", alu_enable, 1'b0);
    end
    resp_ready = '1;
    drain();

    // Operand change after grant must not affect the result.
    rlog.delete();
    set_req(2, OP_ADD, 32'd5, 32'd3, 32'd0, 1);
    wait_grant(2);
    req_rs1[2*DW +: DW] = 32'd100;
    drain();
    check("iso_results", rlog.size(), 1);
    if (rlog.size() == 1) check("iso_data", rlog[0], 32'd8);

    // Reset while the operation sits in WAIT.
    set_req(1, OP_SUB, 32'd50, 32'd8, 32'd0, 1);
    wait_grant(1);
    step();
    check("mid_busy_before", busy, 1'b1);
    arm(3, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_req_ready", req_ready, '0);
    check("mid_resp_valid", resp_valid, '0);
    check("mid_alu_enable", alu_enable, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_grant_id", grant_id, '0);
    check("mid_resp_data", resp_data, '0);
    check("mid_alu_rs1", alu_rs1, '0);
    check("mid_alu_instr", alu_instruction, '0);
    step();
    step();
    reset = 1'b1;
    arm(0, 1);
    #1 check("mid_ptr_reset", req_ready, 4'b0001);
    drain();

    // Random traffic against the model.
    rand_mode = 1'b1;
    repeat (400) step();
    rand_mode = 1'b0;
    resp_ready = '1;
    drain();
    step();
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
